// File: rtl/dual_byte_uart_rx_if.sv
// Output bus of the dual-byte receiver: recovered byte pair, strobes and error count.
interface dual_byte_uart_rx_if #(
  parameter int ERRCNT_W = 8
);
  logic [7:0]          a_data;
  logic [7:0]          b_data;
  logic                data_valid;
  logic                frame_err;
  logic [ERRCNT_W-1:0] err_cnt;

  modport master (output a_data, b_data, data_valid, frame_err, err_cnt);
  modport slave  (input  a_data, b_data, data_valid, frame_err, err_cnt);
endinterface

// File: rtl/dual_byte_uart_rx.sv
// Oversampling receiver for the 23-bit dual-byte AD-sample frame.
// Recovers the A/B byte pair, rejects malformed frames and counts them.
module dual_byte_uart_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int ERRCNT_W   = 8
) (
  input  logic                clk_16M,
  input  logic                rst,
  input  logic                rs232_rx,
  dual_byte_uart_rx_if.master rx_bus
);

  localparam int H  = OVERSAMPLE / 2;
  localparam int TW = $clog2(OVERSAMPLE);

  localparam logic [TW-1:0]       TICK_S0   = TW'(H - 1);
  localparam logic [TW-1:0]       TICK_S1   = TW'(H);
  localparam logic [TW-1:0]       TICK_DEC  = TW'(H + 1);
  localparam logic [TW-1:0]       TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [ERRCNT_W-1:0] ERR_MAX   = {ERRCNT_W{1'b1}};

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic                sync_ff1_r;
  logic                sync_ff2_r;
  logic                prev_r;
  logic                rx_s;
  logic                edge_s;

  state_t              state_r;
  logic [TW-1:0]       tick_r;
  logic [4:0]          k_r;
  logic [TW-1:0]       hi_cnt_r;
  logic                s0_r;
  logic                s1_r;
  logic                bad_r;
  logic [7:0]          a_sh_r;
  logic [7:0]          b_sh_r;

  logic [7:0]          a_data_r;
  logic [7:0]          b_data_r;
  logic                data_valid_r;
  logic                frame_err_r;
  logic [ERRCNT_W-1:0] err_cnt_r;

  logic [TW-1:0]       tick_nxt_s;
  logic [4:0]          k_nxt_s;
  logic                dec_s;
  logic                bit_s;
  logic                zero_bit_s;
  logic                a_bit_s;
  logic                b_bit_s;

  assign rx_s   = sync_ff2_r;
  assign edge_s = ~rx_s & prev_r;
  assign dec_s  = (tick_r == TICK_DEC);
  assign bit_s  = maj3(s0_r, s1_r, rx_s);

  // Two-flop synchroniser plus one-cycle history for falling-edge detection.
  always_ff @(posedge clk_16M or negedge rst) begin
    if (!rst) begin
      sync_ff1_r <= 1'b1;
      sync_ff2_r <= 1'b1;
      prev_r     <= 1'b1;
    end else begin
      sync_ff1_r <= rs232_rx;
      sync_ff2_r <= sync_ff1_r;
      prev_r     <= sync_ff2_r;
    end
  end

  // Oversample tick and bit-index advance.
  always_comb begin
    if (tick_r == TICK_LAST) begin
      tick_nxt_s = '0;
      k_nxt_s    = k_r + 5'd1;
    end else begin
      tick_nxt_s = tick_r + TW'(1);
      k_nxt_s    = k_r;
    end
  end

  // Classify the current bit index: fixed-zero, channel A or channel B.
  always_comb begin
    zero_bit_s = 1'b0;
    a_bit_s    = 1'b0;
    b_bit_s    = 1'b0;
    case (k_r)
      5'd1, 5'd10, 5'd11, 5'd20, 5'd21:                        zero_bit_s = 1'b1;
      5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9:          a_bit_s    = 1'b1;
      5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd17, 5'd18, 5'd19:  b_bit_s    = 1'b1;
      default:                                                 zero_bit_s = 1'b0;
    endcase
  end

  // Frame FSM with sampling, shift registers and registered outputs.
  always_ff @(posedge clk_16M or negedge rst) begin
    if (!rst) begin
      state_r      <= IDLE;
      tick_r       <= '0;
      k_r          <= 5'd0;
      hi_cnt_r     <= '0;
      s0_r         <= 1'b1;
      s1_r         <= 1'b1;
      bad_r        <= 1'b0;
      a_sh_r       <= 8'h00;
      b_sh_r       <= 8'h00;
      a_data_r     <= 8'h00;
      b_data_r     <= 8'h00;
      data_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
      err_cnt_r    <= '0;
    end else begin
      data_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
      if (tick_r == TICK_S0) begin
        s0_r <= rx_s;
      end
      if (tick_r == TICK_S1) begin
        s1_r <= rx_s;
      end

      case (state_r)
        IDLE: begin
          k_r      <= 5'd0;
          hi_cnt_r <= '0;
          if (edge_s) begin
            // The edge cycle itself is tick 0, so the next cycle is tick 1.
            state_r <= START;
            tick_r  <= TW'(1);
            bad_r   <= 1'b0;
          end else begin
            tick_r  <= '0;
          end
        end

        START: begin
          tick_r <= tick_nxt_s;
          k_r    <= k_nxt_s;
          if (dec_s) begin
            if (bit_s) begin
              state_r <= IDLE;
              tick_r  <= '0;
              k_r     <= 5'd0;
            end else begin
              state_r <= DATA;
            end
          end
        end

        DATA: begin
          tick_r <= tick_nxt_s;
          k_r    <= k_nxt_s;
          if (dec_s) begin
            if (zero_bit_s && bit_s) begin
              bad_r <= 1'b1;
            end
            if (a_bit_s) begin
              a_sh_r <= {bit_s, a_sh_r[7:1]};
            end
            if (b_bit_s) begin
              b_sh_r <= {bit_s, b_sh_r[7:1]};
            end
            if (k_r == 5'd21) begin
              state_r <= STOP;
            end
          end
        end

        STOP: begin
          tick_r <= tick_nxt_s;
          k_r    <= k_nxt_s;
          if (dec_s) begin
            tick_r <= '0;
            k_r    <= 5'd0;
            if (bit_s && !bad_r) begin
              a_data_r     <= a_sh_r;
              b_data_r     <= b_sh_r;
              data_valid_r <= 1'b1;
              state_r      <= IDLE;
            end else begin
              frame_err_r <= 1'b1;
              if (err_cnt_r != ERR_MAX) begin
                err_cnt_r <= err_cnt_r + ERRCNT_W'(1);
              end
              // A low stop bit means the line may be stuck low; wait for a clean idle.
              state_r  <= bit_s ? IDLE : BREAK;
              hi_cnt_r <= '0;
            end
          end
        end

        BREAK: begin
          tick_r <= '0;
          k_r    <= 5'd0;
          if (!rx_s) begin
            hi_cnt_r <= '0;
          end else if (hi_cnt_r == TICK_LAST) begin
            hi_cnt_r <= '0;
            state_r  <= IDLE;
          end else begin
            hi_cnt_r <= hi_cnt_r + TW'(1);
          end
        end

        default: begin
          state_r <= IDLE;
          tick_r  <= '0;
          k_r     <= 5'd0;
        end
      endcase
    end
  end

  assign rx_bus.a_data     = a_data_r;
  assign rx_bus.b_data     = b_data_r;
  assign rx_bus.data_valid = data_valid_r;
  assign rx_bus.frame_err  = frame_err_r;
  assign rx_bus.err_cnt    = err_cnt_r;

endmodule

// File: tb/tb_dual_byte_uart_rx.sv
// Scoreboard bench for dual_byte_uart_rx: good frames, back-to-back, glitch, bad frames, break, saturation, reset.
`timescale 1ns/1ps
module tb_dual_byte_uart_rx;

  localparam int OS     = 16;
  localparam int EW     = 3;
  localparam int ERRMAX = (1 << EW) - 1;
  // Two synchroniser cycles plus the edge-to-data_valid distance of 22*OS + OS/2 + 2.
  localparam int DV_LAT = 2 + 22 * OS + OS / 2 + 2;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    int         t;
  } exp_t;

  logic clk_16M  = 1'b0;
  logic rst      = 1'b0;
  logic rs232_rx = 1'b1;

  int   cyc      = 0;
  int   checks   = 0;
  int   errors   = 0;
  int   dv_count = 0;
  int   fe_count = 0;
  int   exp_err  = 0;
  exp_t sb_q[$];

  dual_byte_uart_rx_if #(.ERRCNT_W(EW)) bus ();

  dual_byte_uart_rx #(.OVERSAMPLE(OS), .ERRCNT_W(EW)) dut (
    .clk_16M (clk_16M),
    .rst     (rst),
    .rs232_rx(rs232_rx),
    .rx_bus  (bus)
  );

  always #5 clk_16M = ~clk_16M;

  always @(posedge clk_16M) cyc <= cyc + 1;

  // Monitor: every data_valid pulse is matched against the scoreboard head.
  always @(negedge clk_16M) begin
    if (bus.data_valid === 1'b1) begin
      exp_t e;
      dv_count++;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_dv: a=%h b=%h at cycle %0d, no frame expected", bus.a_data, bus.b_data, cyc);
      end else begin
        e = sb_q.pop_front();
        if (bus.a_data !== e.a || bus.b_data !== e.b || cyc != e.t || bus.frame_err !== 1'b0) begin
          errors++;
          $display("FAIL frame_data: got a=%h b=%h cycle=%0d fe=%b, want a=%h b=%h cycle=%0d fe=0",
                   bus.a_data, bus.b_data, cyc, bus.frame_err, e.a, e.b, e.t);
        end
      end
    end
    if (bus.frame_err === 1'b1) fe_count++;
  end

  function automatic logic [22:0] make_frame(input logic [7:0] a, input logic [7:0] b);
    logic [22:0] f;
    f = '0;
    for (int i = 0; i < 8; i++) begin
      f[2 + i]  = a[i];
      f[12 + i] = b[i];
    end
    f[22] = 1'b1;
    return f;
  endfunction

  task automatic send_frame(input logic [22:0] f, input int nbits, input bit exp_good,
                            input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    for (int k = 0; k < nbits; k++) begin
      @(posedge clk_16M); #1;
      rs232_rx = f[k];
      if (k == 0 && exp_good) begin
        e.a = a;
        e.b = b;
        e.t = cyc + DV_LAT;
        sb_q.push_back(e);
      end
      repeat (OS - 1) @(posedge clk_16M);
    end
  endtask

  task automatic drive_line(input logic v, input int n);
    @(posedge clk_16M); #1;
    rs232_rx = v;
    repeat (n - 1) @(posedge clk_16M);
  endtask

  task automatic wait_sb_empty(input string name);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(posedge clk_16M);
      n++;
    end
    @(negedge clk_16M);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: %0d frames still pending, want 0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk_16M);
    @(negedge clk_16M);
    checks++;
    if (bus.a_data !== 8'h00 || bus.b_data !== 8'h00 || bus.data_valid !== 1'b0 ||
        bus.frame_err !== 1'b0 || bus.err_cnt !== 3'd0) begin
      errors++;
      $display("FAIL reset_values: a=%h b=%h dv=%b fe=%b cnt=%0d, want all 0",
               bus.a_data, bus.b_data, bus.data_valid, bus.frame_err, bus.err_cnt);
    end
    @(posedge clk_16M); #1;
    rst = 1'b1;
    repeat (20) @(posedge clk_16M);
    @(negedge clk_16M);
    checks++;
    if (bus.a_data !== 8'h00 || bus.err_cnt !== 3'd0 || dv_count != 0 || fe_count != 0) begin
      errors++;
      $display("FAIL post_reset_idle: a=%h cnt=%0d dv=%0d fe=%0d, want 0/0/0/0",
               bus.a_data, bus.err_cnt, dv_count, fe_count);
    end
  endtask

  task automatic test_single_frame();
    int dv0;
    dv0 = dv_count;
    send_frame(make_frame(8'hA5, 8'h3C), 23, 1'b1, 8'hA5, 8'h3C);
    drive_line(1'b1, OS);
    wait_sb_empty("single");
    checks++;
    if (dv_count != dv0 + 1 || fe_count != 0 || bus.err_cnt !== 3'd0 ||
        bus.a_data !== 8'hA5 || bus.b_data !== 8'h3C) begin
      errors++;
      $display("FAIL single_frame: dv=%0d fe=%0d cnt=%0d a=%h b=%h, want dv=%0d fe=0 cnt=0 a=a5 b=3c",
               dv_count - dv0, fe_count, bus.err_cnt, bus.a_data, bus.b_data, 1);
    end
  endtask

  task automatic test_back_to_back();
    int dv0;
    dv0 = dv_count;
    send_frame(make_frame(8'h01, 8'h80), 23, 1'b1, 8'h01, 8'h80);
    drive_line(1'b1, OS);
    send_frame(make_frame(8'hFF, 8'h00), 23, 1'b1, 8'hFF, 8'h00);
    drive_line(1'b1, OS);
    wait_sb_empty("back_to_back");
    checks++;
    if (dv_count != dv0 + 2 || bus.err_cnt !== 3'd0 || fe_count != 0) begin
      errors++;
      $display("FAIL back_to_back: dv=%0d cnt=%0d fe=%0d, want dv=2 cnt=0 fe=0",
               dv_count - dv0, bus.err_cnt, fe_count);
    end
  endtask

  task automatic test_glitch();
    int dv0;
    int fe0;
    dv0 = dv_count;
    fe0 = fe_count;
    drive_line(1'b1, 20);
    drive_line(1'b0, 4);
    drive_line(1'b1, 60);
    @(negedge clk_16M);
    checks++;
    if (dv_count != dv0 || fe_count != fe0 || bus.err_cnt !== 3'd0) begin
      errors++;
      $display("FAIL glitch: dv=%0d fe=%0d cnt=%0d, want 0/0/0", dv_count - dv0, fe_count - fe0, bus.err_cnt);
    end
    send_frame(make_frame(8'h5A, 8'hC3), 23, 1'b1, 8'h5A, 8'hC3);
    drive_line(1'b1, OS);
    wait_sb_empty("after_glitch");
    checks++;
    if (dv_count != dv0 + 1 || bus.a_data !== 8'h5A || bus.b_data !== 8'hC3) begin
      errors++;
      $display("FAIL after_glitch: dv=%0d a=%h b=%h, want dv=1 a=5a b=c3", dv_count - dv0, bus.a_data, bus.b_data);
    end
  endtask

  task automatic test_separator();
    logic [22:0] f;
    int dv0;
    int fe0;
    dv0 = dv_count;
    fe0 = fe_count;
    f = make_frame(8'h12, 8'h34);
    f[11] = 1'b1;
    send_frame(f, 23, 1'b0, 8'h00, 8'h00);
    drive_line(1'b1, 2 * OS);
    exp_err++;
    @(negedge clk_16M);
    checks++;
    if (fe_count != fe0 + 1 || dv_count != dv0 || bus.err_cnt !== 3'(exp_err) ||
        bus.a_data !== 8'h5A || bus.b_data !== 8'hC3) begin
      errors++;
      $display("FAIL separator: fe=%0d dv=%0d cnt=%0d a=%h b=%h, want fe=1 dv=0 cnt=%0d a=5a b=c3",
               fe_count - fe0, dv_count - dv0, bus.err_cnt, bus.a_data, bus.b_data, exp_err);
    end
  endtask

  task automatic test_stop_break();
    int dv0;
    int fe0;
    dv0 = dv_count;
    fe0 = fe_count;
    send_frame(make_frame(8'h66, 8'h99), 22, 1'b0, 8'h00, 8'h00);
    drive_line(1'b0, 100);
    drive_line(1'b1, 8);
    drive_line(1'b0, 20);
    drive_line(1'b1, 400);
    exp_err++;
    @(negedge clk_16M);
    checks++;
    if (fe_count != fe0 + 1 || dv_count != dv0 || bus.err_cnt !== 3'(exp_err) ||
        bus.a_data !== 8'h5A || bus.b_data !== 8'hC3) begin
      errors++;
      $display("FAIL stop_break: fe=%0d dv=%0d cnt=%0d a=%h b=%h, want fe=1 dv=0 cnt=%0d a=5a b=c3",
               fe_count - fe0, dv_count - dv0, bus.err_cnt, bus.a_data, bus.b_data, exp_err);
    end
    send_frame(make_frame(8'h9E, 8'h21), 23, 1'b1, 8'h9E, 8'h21);
    drive_line(1'b1, OS);
    wait_sb_empty("after_break");
    checks++;
    if (bus.a_data !== 8'h9E || bus.b_data !== 8'h21 || fe_count != fe0 + 1) begin
      errors++;
      $display("FAIL after_break: a=%h b=%h fe=%0d, want a=9e b=21 fe=1", bus.a_data, bus.b_data, fe_count - fe0);
    end
  endtask

  task automatic test_saturation();
    logic [22:0] f;
    int fe0;
    f = make_frame(8'hC0, 8'h03);
    f[20] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      fe0 = fe_count;
      send_frame(f, 23, 1'b0, 8'h00, 8'h00);
      drive_line(1'b1, OS);
      if (exp_err < ERRMAX) exp_err++;
      @(negedge clk_16M);
      checks++;
      if (bus.err_cnt !== 3'(exp_err) || fe_count != fe0 + 1) begin
        errors++;
        $display("FAIL saturation_%0d: cnt=%0d fe=%0d, want cnt=%0d fe=1", i, bus.err_cnt, fe_count - fe0, exp_err);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [22:0] f;
    f = make_frame(8'hDE, 8'hAD);
    send_frame(f, 14, 1'b0, 8'h00, 8'h00);
    @(posedge clk_16M); #1;
    rs232_rx = f[14];
    repeat (5) @(posedge clk_16M);
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.a_data !== 8'h00 || bus.b_data !== 8'h00 || bus.data_valid !== 1'b0 ||
        bus.frame_err !== 1'b0 || bus.err_cnt !== 3'd0) begin
      errors++;
      $display("FAIL mid_reset: a=%h b=%h dv=%b fe=%b cnt=%0d, want all 0",
               bus.a_data, bus.b_data, bus.data_valid, bus.frame_err, bus.err_cnt);
    end
    exp_err = 0;
    rs232_rx = 1'b1;
    repeat (4) @(posedge clk_16M);
    #1;
    rst = 1'b1;
    drive_line(1'b1, 40);
    send_frame(make_frame(8'h77, 8'h88), 23, 1'b1, 8'h77, 8'h88);
    drive_line(1'b1, OS);
    wait_sb_empty("after_reset");
    checks++;
    if (bus.a_data !== 8'h77 || bus.b_data !== 8'h88 || bus.err_cnt !== 3'd0) begin
      errors++;
      $display("FAIL after_reset: a=%h b=%h cnt=%0d, want a=77 b=88 cnt=0", bus.a_data, bus.b_data, bus.err_cnt);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_glitch();
    test_separator();
    test_stop_break();
    test_saturation();
    test_mid_reset();
    repeat (5) @(posedge clk_16M);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dual_byte_uart_rx.md
Name: dual_byte_uart_rx

Overview:
- Receiver for the 23-bit dual-byte serial frame produced by the on-board AD-sample transmitter. That transmitter sends one bit per clk_1M cycle, i.e. 1 Mbit/s.
- Oversamples the line on the 16 MHz system clock, checks the frame structure, and recovers channel A and channel B bytes.
- Sits at the far end of the serial link and feeds the demodulator/DAC stage with byte pairs, plus a valid strobe.

Parameters:
- OVERSAMPLE, 16, clock cycles per bit; minimum 8, must be even; H = OVERSAMPLE/2.
- ERRCNT_W, 8, width of the saturating frame-error counter.

Ports:
- clk_16M  input  1  system clock, OVERSAMPLE × bit rate
- rst  input  1  asynchronous, active-low reset
- rs232_rx  input  1  serial line, idle high, asynchronous to clk_16M
- a_data  output  8  channel A byte of the last good frame
- b_data  output  8  channel B byte of the last good frame
- data_valid  output  1  one-cycle pulse when a_data/b_data update
- frame_err  output  1  one-cycle pulse on a rejected frame
- err_cnt  output  ERRCNT_W  count of rejected frames, saturating

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: a_data=0, b_data=0, data_valid=0, frame_err=0, err_cnt=0. Synchroniser flops reset to 1. State=IDLE.
- Synchronisation: rs232_rx passes through a 2-FF synchroniser to give rx_s. All logic uses rx_s only.
- Frame, bit index k = 0..22:
  - k = 0,1: start, must be 0.
  - k = 2..9: A[0..7], LSB first.
  - k = 10,11: separator, must be 0.
  - k = 12..19: B[0..7], LSB first.
  - k = 20,21: check bits, must be 0.
  - k = 22: stop, must be 1.
- Counters:
  - tick: 0..OVERSAMPLE-1. Wraps and increments bit index k.
  - k: 0..22.
- Sampling: 3-sample majority of rx_s at tick H-1, H, H+1. The bit decision is made at tick H+1.
- Edge cycle E: the cycle in which rx_s=0 and its previous value was 1 while in IDLE. tick=0, k=0 at E. Bit k is decided at cycle E + k·OVERSAMPLE + H + 1.
- IDLE:
  - Wait for a falling edge on rx_s, then go to START.
- START (k=0):
  - Majority 1: glitch. Return to IDLE with no error pulse and no count.
  - Majority 0: go to DATA.
- DATA (k=1..21):
  - Shift A and B bits into internal shift registers.
  - Any violated fixed-zero bit (k=1,10,11,20,21) sets a sticky bad flag. Reception continues to k=22.
- STOP (k=22), decided at its sample point:
  - Stop=1 and bad=0: in the next cycle, load a_data/b_data, pulse data_valid, go to IDLE. data_valid therefore fires at E + 22·OVERSAMPLE + H + 2 (E+362 for the default).
  - Stop=1 and bad=1: in the next cycle, pulse frame_err, increment err_cnt, go to IDLE. Data outputs are unchanged.
  - Stop=0: in the next cycle, pulse frame_err, increment err_cnt, go to BREAK.
- BREAK:
  - Stay until rx_s has been 1 for OVERSAMPLE consecutive cycles, then go to IDLE.
  - Falling edges are ignored in BREAK.
- Return to IDLE happens mid-stop-bit. A new start edge is therefore accepted as soon as the transmitter's minimum idle gap ends: stop bit plus one idle bit.
- Outputs hold the last good frame. data_valid and frame_err are never asserted together.
- err_cnt saturates at 2^ERRCNT_W - 1.
- Reset mid-frame: all state returns to reset values immediately. Partially received data is discarded.

Test Plan:
- Frame A=0xA5, B=0x3C at 16 cycles/bit → a_data=0xA5, b_data=0x3C, data_valid high for exactly 1 cycle at E+362, frame_err never asserted.
- Two frames back-to-back (0x01/0x80 then 0xFF/0x00) with only a 2-bit-time high gap → two data_valid pulses with correct byte pairs, err_cnt=0.
- 4-cycle low glitch on an idle line → no data_valid, no frame_err, err_cnt=0; a following good frame 0x5A/0xC3 is received correctly.
- Frame 0x12/0x34 with separator bit k=11 driven 1 → frame_err pulse, err_cnt=1, a_data/b_data keep the previous values.
- Frame with stop bit low, line held low 100 cycles then high → one frame_err pulse, err_cnt=1, no new frame accepted until the line has been high 16 cycles; the next good frame is received.
- rst asserted at bit k=14 of a frame → all outputs 0 immediately; after release, the next frame 0x77/0x88 is received correctly.
